// File: rtl/csv_pkg.sv
// Shared constants, FSM state type and BCD helpers for the CSV word writer.
package csv_pkg;

  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_MINUS = 8'h2D;
  localparam logic [7:0] CHAR_COMMA = 8'h2C;
  localparam logic [7:0] CHAR_NL    = 8'h0A;
  localparam int NUM_DIGITS = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    SIGN    = 3'd2,
    DIGITS  = 3'd3,
    SEP     = 3'd4
  } state_e;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in bit_in.
  function automatic logic [39:0] dd_step(input logic [39:0] bcd, input logic bit_in);
    logic [39:0] adj;
    logic [3:0]  d;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = bcd[i*4 +: 4];
      adj[i*4 +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
    return {adj[38:0], bit_in};
  endfunction

  function automatic logic [3:0] bcd_digit(input logic [39:0] bcd, input logic [3:0] idx);
    return bcd[int'(idx)*4 +: 4];
  endfunction

  // Index of the most significant non-zero digit; 0 when the value is zero.
  function automatic logic [3:0] msd_index(input logic [39:0] bcd);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: the first iteration happens on the start
// edge, the remaining 31 on the following edges; done rises with the final one.
module bin2bcd
  import csv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        done,
  output logic [39:0] bcd
);

  logic [31:0] shift_r;
  logic [39:0] bcd_r;
  logic [4:0]  cnt_r;
  logic        active_r;
  logic        done_r;

  // Iteration register: load and first step on start, then one step per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r  <= 32'd0;
      bcd_r    <= 40'd0;
      cnt_r    <= 5'd0;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else if (start) begin
      bcd_r    <= dd_step(40'd0, bin[31]);
      shift_r  <= {bin[30:0], 1'b0};
      cnt_r    <= 5'd1;
      active_r <= 1'b1;
      done_r   <= 1'b0;
    end else if (active_r) begin
      bcd_r   <= dd_step(bcd_r, shift_r[31]);
      shift_r <= {shift_r[30:0], 1'b0};
      cnt_r   <= cnt_r + 5'd1;
      if (cnt_r == 5'd31) begin
        active_r <= 1'b0;
        done_r   <= 1'b1;
      end
    end
  end

  assign done = done_r;
  assign bcd  = bcd_r;

endmodule

// File: rtl/csv_word_writer.sv
// Formats 32-bit words as decimal ASCII followed by a separator or end-of-line.
// Define CSV_WRITER_SIGNED_EN to treat words as two's complement with a '-' prefix.
module csv_word_writer
  import csv_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR = 8'h2C,
  parameter logic [7:0] EOL_CHAR = 8'h0A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  state_e      state_r, state_n;
  logic [3:0]  idx_r, idx_n;
  logic [7:0]  out_data_r, out_data_n;
  logic        out_valid_r, out_valid_n;
  logic        in_ready_r;
  logic        last_r, neg_r;
  logic        accept_s, neg_s, done_s;
  logic [31:0] mag_s;
  logic [39:0] bcd_s;
  logic [3:0]  msd_s;

  assign accept_s = in_valid && in_ready_r;

`ifdef CSV_WRITER_SIGNED_EN
  assign neg_s = in_data[31];
  assign mag_s = neg_s ? (~in_data + 32'd1) : in_data;
`else
  assign neg_s = 1'b0;
  assign mag_s = in_data;
`endif

  assign msd_s = msd_index(bcd_s);

  bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept_s),
    .bin   (mag_s),
    .done  (done_s),
    .bcd   (bcd_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_n;
  end

  // Next state and next output character; idx_r points at the digit on out_data.
  always_comb begin
    state_n     = state_r;
    idx_n       = idx_r;
    out_valid_n = out_valid_r;
    out_data_n  = out_data_r;
    case (state_r)
      IDLE: begin
        out_valid_n = 1'b0;
        if (accept_s) state_n = CONVERT;
        else          state_n = IDLE;
      end
      CONVERT: begin
        if (done_s) begin
          idx_n       = msd_s;
          out_valid_n = 1'b1;
          if (neg_r) begin
            state_n    = SIGN;
            out_data_n = CHAR_MINUS;
          end else begin
            state_n    = DIGITS;
            out_data_n = CHAR_ZERO + {4'd0, bcd_digit(bcd_s, msd_s)};
          end
        end else begin
          state_n = CONVERT;
        end
      end
      SIGN: begin
        if (out_ready) begin
          state_n    = DIGITS;
          out_data_n = CHAR_ZERO + {4'd0, bcd_digit(bcd_s, idx_r)};
        end else begin
          state_n = SIGN;
        end
      end
      DIGITS: begin
        if (out_ready) begin
          if (idx_r == 4'd0) begin
            state_n    = SEP;
            out_data_n = last_r ? EOL_CHAR : SEP_CHAR;
          end else begin
            idx_n      = idx_r - 4'd1;
            out_data_n = CHAR_ZERO + {4'd0, bcd_digit(bcd_s, idx_r - 4'd1)};
          end
        end else begin
          state_n = DIGITS;
        end
      end
      SEP: begin
        if (out_ready) begin
          state_n     = IDLE;
          out_valid_n = 1'b0;
          out_data_n  = 8'h00;
        end else begin
          state_n = SEP;
        end
      end
      default: begin
        state_n     = IDLE;
        out_valid_n = 1'b0;
        out_data_n  = 8'h00;
      end
    endcase
  end

  // Registered outputs and per-word attributes captured at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      in_ready_r  <= 1'b1;
      idx_r       <= 4'd0;
      last_r      <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      out_valid_r <= out_valid_n;
      out_data_r  <= out_data_n;
      in_ready_r  <= (state_n == IDLE);
      idx_r       <= idx_n;
      if (accept_s) begin
        last_r <= in_last;
        neg_r  <= neg_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = !in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_csv_word_writer.sv
// Scoreboard bench for csv_word_writer: expected characters queued at acceptance,
// checked by an independent output monitor.
module tb_csv_word_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = 32'd0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int xfer_cnt = 0;
  bit lat_pending = 1'b0;

  csv_word_writer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: latency of first char, each transferred char, and hold during stalls.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (lat_pending) begin
        check("first_char_latency", cyc - acc_cyc, 32);
        lat_pending = 1'b0;
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_char", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          check("char", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
        xfer_cnt++;
      end else if (exp_q.size() != 0) begin
        check("stall_hold", {24'd0, out_data}, {24'd0, exp_q[0]});
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l, input string s);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      timeout("accept");
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid    = 1'b0;
      acc_cyc     = cyc;
      lat_pending = 1'b1;
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || !in_ready) timeout("drain");
  endtask

  task automatic wait_xfers(input int target);
    int n;
    n = 0;
    while (xfer_cnt < target && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (xfer_cnt < target) timeout("wait_xfers");
  endtask

  task automatic pulse_reset(input logic with_valid);
    rst      = 1'b1;
    in_valid = with_valid;
    in_data  = 32'd5;
    exp_q.delete();
    lat_pending = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {24'd0, out_data}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);

    send(32'd0, 1'b1, "0\n");
    drain();

    send(32'd1, 1'b0, "1,");
    send(32'd23, 1'b0, "23,");
    send(32'd456, 1'b1, "456\n");
    drain();

`ifdef CSV_WRITER_SIGNED_EN
    send(32'h8000_0000, 1'b0, "-2147483648,");
    send(32'hFFFF_FFFF, 1'b1, "-1\n");
`else
    send(32'h8000_0000, 1'b0, "2147483648,");
    send(32'hFFFF_FFFF, 1'b1, "4294967295\n");
`endif
    drain();

    base = xfer_cnt;
    send(32'd1000, 1'b0, "1000,");
    wait_xfers(base + 2);
    out_ready = 1'b0;
    check("stall_data", {24'd0, out_data}, 32'h30);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_data", {24'd0, out_data}, 32'h30);
    end
    out_ready = 1'b1;
    drain();

    send(32'd77, 1'b0, "77,");
    repeat (10) @(posedge clk);
    #1;
    pulse_reset(1'b1);
    send(32'd5, 1'b1, "5\n");
    drain();

    base = xfer_cnt;
    send(32'd12345, 1'b1, "12345\n");
    wait_xfers(base + 2);
    pulse_reset(1'b0);
    send(32'd9, 1'b1, "9\n");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
